// File: rtl/grid_renderer.sv
// grid_renderer: walks the game grid row-major after each enemy update pass
// and paints every cell as a 4x4 pixel block into the VGA frame buffer.
// The grid is only read; the address is held from READ through ADVANCE so
// the registered RAM read always sees a stable address.
module grid_renderer #(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [5:0] grid_x,
  output logic [4:0] grid_y,
  input  logic [2:0] grid_out,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_DRAW, S_ADVANCE, S_DONE
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [5:0] r_cell_x, w_cell_x_nxt;
  logic [4:0] r_cell_y, w_cell_y_nxt;
  logic [1:0] r_px, w_px_nxt;
  logic [1:0] r_py, w_py_nxt;
  logic [2:0] r_colour, w_colour_nxt;
  logic       w_last_x, w_last_y;
  logic [2:0] w_map;

  assign w_last_x = (r_cell_x == 6'(GRID_W - 1));
  assign w_last_y = (r_cell_y == 5'(GRID_H - 1));

  // Cell contents to {R,G,B}; codes 5..7 are illegal and shown magenta.
  always_comb begin
    w_map = 3'b101;
    case (grid_out)
      3'd0: w_map = 3'b000;
      3'd1: w_map = 3'b111;
      3'd2: w_map = 3'b010;
      3'd3: w_map = 3'b110;
      3'd4: w_map = 3'b100;
      default: w_map = 3'b101;
    endcase
  end

  // State, cell/pixel counters and colour register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cell_x <= '0;
      r_cell_y <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_colour <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cell_x <= w_cell_x_nxt;
      r_cell_y <= w_cell_y_nxt;
      r_px     <= w_px_nxt;
      r_py     <= w_py_nxt;
      r_colour <= w_colour_nxt;
    end
  end

  // Next-state, counter updates and state-decoded strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_cell_x_nxt = r_cell_x;
    w_cell_y_nxt = r_cell_y;
    w_px_nxt     = r_px;
    w_py_nxt     = r_py;
    w_colour_nxt = r_colour;
    busy         = 1'b1;
    done         = 1'b0;
    vga_plot     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_READ;
      end
      // Address is on grid_x/grid_y; RAM registers it at the end of this cycle.
      S_READ: w_state_nxt = S_LATCH;
      S_LATCH: begin
        w_colour_nxt = w_map;
        w_px_nxt     = '0;
        w_py_nxt     = '0;
        w_state_nxt  = S_DRAW;
      end
      // 2-bit px/py wrap naturally, leaving both at 0 after the 16th pixel.
      S_DRAW: begin
        vga_plot = 1'b1;
        w_px_nxt = r_px + 2'd1;
        if (r_px == 2'd3) w_py_nxt = r_py + 2'd1;
        if (r_px == 2'd3 && r_py == 2'd3) w_state_nxt = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (w_last_x && w_last_y) begin
          w_state_nxt = S_DONE;
        end else if (w_last_x) begin
          w_cell_x_nxt = '0;
          w_cell_y_nxt = r_cell_y + 5'd1;
          w_state_nxt  = S_READ;
        end else begin
          w_cell_x_nxt = r_cell_x + 6'd1;
          w_state_nxt  = S_READ;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_cell_x_nxt = '0;
        w_cell_y_nxt = '0;
        w_px_nxt     = '0;
        w_py_nxt     = '0;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign grid_x     = r_cell_x;
  assign grid_y     = r_cell_y;
  assign vga_x      = {r_cell_x, r_px};
  assign vga_y      = {r_cell_y, r_py};
  assign vga_colour = r_colour;

endmodule

// File: tb/tb_grid_renderer.sv
// Testbench for grid_renderer: a registered-read grid RAM model feeds the DUT,
// expected plots are queued on start and popped as vga_plot strobes appear.
module tb_grid_renderer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       done, busy, vga_plot;
  logic [5:0] grid_x;
  logic [4:0] grid_y;
  logic [2:0] grid_out = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } plot_t;

  plot_t      sb[$];
  logic [2:0] mem [0:29][0:39];
  int         n_checks = 0;
  int         n_pass   = 0;

  grid_renderer dut (
    .clock(clock), .reset(reset), .start(start), .done(done), .busy(busy),
    .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #10 clock = ~clock;

  // Registered RAM read: data for an address appears one clock later.
  always @(posedge clock) begin
    if (grid_x < 6'd40 && grid_y < 5'd30) grid_out <= mem[grid_y][grid_x];
    else grid_out <= 3'd0;
  end

  function automatic logic [2:0] cmap(input logic [2:0] v);
    logic [2:0] tbl [0:7];
    tbl = '{3'b000, 3'b111, 3'b010, 3'b110, 3'b100, 3'b101, 3'b101, 3'b101};
    return tbl[v];
  endfunction

  task automatic load_grid;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++) mem[y][x] = 3'd0;
    mem[0][0]   = 3'd1;
    mem[29][39] = 3'd4;
    for (int v = 0; v < 8; v++) mem[15][v] = 3'(v);
  endtask

  task automatic push_frame;
    sb.delete();
    for (int cy = 0; cy < 30; cy++)
      for (int cx = 0; cx < 40; cx++)
        for (int py = 0; py < 4; py++)
          for (int px = 0; px < 4; px++)
            sb.push_back('{x: 8'(cx * 4 + px), y: 7'(cy * 4 + py), c: cmap(mem[cy][cx])});
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({done, busy, vga_plot} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {done, busy, vga_plot});
    else n_pass++;
    n_checks++;
    if ({grid_x, grid_y, vga_x, vga_y, vga_colour} !== '0)
      $display("FAIL reset_regs got gx=%0d gy=%0d vx=%0d vy=%0d c=%b want all 0", grid_x, grid_y, vga_x, vga_y, vga_colour);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Full frame with extra start pulses at cycle 500 and in the done cycle.
  task automatic test_full_frame;
    int plots = 0, first_plot = 0, last_plot = 0;
    int done_cnt = 0, done_cyc = 0, busy_cnt = 0, busy_first = 0, busy_last = 0;
    plot_t exp_p;
    push_frame();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 22804; c++) begin
      if (busy) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (vga_plot) begin
        if (plots == 0) first_plot = c;
        last_plot = c;
        if (plots == 0 || plots == 16 || plots == 19199) begin
          exp_p = (plots == 0) ? '{8'd0, 7'd0, 3'b111} :
                  (plots == 16) ? '{8'd4, 7'd0, 3'b000} : '{8'd159, 7'd119, 3'b100};
          n_checks++;
          if ({vga_x, vga_y, vga_colour} !== exp_p)
            $display("FAIL plot_fixed[%0d] got (%0d,%0d,%b) want (%0d,%0d,%b)", plots,
                     vga_x, vga_y, vga_colour, exp_p.x, exp_p.y, exp_p.c);
          else n_pass++;
        end
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL plot_extra at cycle %0d got (%0d,%0d) want no plot", c, vga_x, vga_y);
        end else begin
          exp_p = sb.pop_front();
          if ({vga_x, vga_y, vga_colour} !== exp_p)
            $display("FAIL plot[%0d] got (%0d,%0d,%b) want (%0d,%0d,%b)", plots,
                     vga_x, vga_y, vga_colour, exp_p.x, exp_p.y, exp_p.c);
          else n_pass++;
        end
        plots++;
      end
      start = (c == 500) || (done === 1'b1);
      @(negedge clock);
    end
    start = 1'b0;
    n_checks++;
    if (plots !== 19200) $display("FAIL plot_count got %0d want 19200", plots); else n_pass++;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL plots_missing got %0d left want 0", sb.size()); else n_pass++;
    n_checks++;
    if (first_plot !== 3 || last_plot !== 22799)
      $display("FAIL plot_window got %0d..%0d want 3..22799", first_plot, last_plot);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1 || done_cyc !== 22801)
      $display("FAIL done_timing got cnt=%0d cyc=%0d want cnt=1 cyc=22801", done_cnt, done_cyc);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== 22801 || busy_first !== 1 || busy_last !== 22801)
      $display("FAIL busy_window got %0d cycles %0d..%0d want 22801 cycles 1..22801", busy_cnt, busy_first, busy_last);
    else n_pass++;
  endtask

  // Reset lands in DRAW of cell (10,5): cycles 3993..4008, cycle 4000 is pixel 7.
  task automatic test_reset_mid;
    int plots = 0, late = 0;
    plot_t exp_p;
    push_frame();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c < 4000; c++) begin
      if (vga_plot) begin
        n_checks++;
        exp_p = sb.pop_front();
        if ({vga_x, vga_y, vga_colour} !== exp_p)
          $display("FAIL mid_plot[%0d] got (%0d,%0d,%b) want (%0d,%0d,%b)", plots,
                   vga_x, vga_y, vga_colour, exp_p.x, exp_p.y, exp_p.c);
        else n_pass++;
        plots++;
      end
      @(negedge clock);
    end
    n_checks++;
    if ({vga_plot, grid_x, grid_y, vga_x, vga_y} !== {1'b1, 6'd10, 5'd5, 8'd43, 7'd21})
      $display("FAIL pre_reset got plot=%b cell=(%0d,%0d) px=(%0d,%0d) want plot=1 cell=(10,5) px=(43,21)",
               vga_plot, grid_x, grid_y, vga_x, vga_y);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({vga_plot, busy, done} !== 3'b000)
      $display("FAIL async_reset got plot=%b busy=%b done=%b want 000", vga_plot, busy, done);
    else n_pass++;
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy || vga_plot) late++;
      @(negedge clock);
    end
    n_checks++;
    if (late !== 0) $display("FAIL post_reset_quiet got %0d active cycles want 0", late); else n_pass++;
  endtask

  // After the aborted frame a new start must render from (0,0) in full.
  task automatic test_rerender;
    int plots = 0, first_plot = 0, done_cyc = 0;
    plot_t exp_p;
    push_frame();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 22803; c++) begin
      if (done && done_cyc == 0) done_cyc = c;
      if (vga_plot) begin
        if (plots == 0) first_plot = c;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL re_plot_extra at cycle %0d got (%0d,%0d) want no plot", c, vga_x, vga_y);
        end else begin
          exp_p = sb.pop_front();
          if ({vga_x, vga_y, vga_colour} !== exp_p)
            $display("FAIL re_plot[%0d] got (%0d,%0d,%b) want (%0d,%0d,%b)", plots,
                     vga_x, vga_y, vga_colour, exp_p.x, exp_p.y, exp_p.c);
          else n_pass++;
        end
        plots++;
      end
      @(negedge clock);
    end
    n_checks++;
    if (plots !== 19200 || first_plot !== 3)
      $display("FAIL re_count got %0d plots first at %0d want 19200 first at 3", plots, first_plot);
    else n_pass++;
    n_checks++;
    if (done_cyc !== 22801) $display("FAIL re_done got cycle %0d want 22801", done_cyc); else n_pass++;
  endtask

  initial begin
    load_grid();
    test_reset();
    test_full_frame();
    test_reset_mid();
    test_rerender();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
